// File: rtl/vga_fill_arb.sv
// Frame-buffer port A arbiter: core loads/stores muxed with a pattern fill engine; core has priority.
// Optional starvation guard enabled by defining VGA_FILL_STARVE_GUARD_EN.
module vga_fill_arb #(
  parameter int FB_DEPTH   = 9600,
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 16
) (
  input  logic              QClk,
  input  logic              ResetN,
  input  logic              CoreWrEn,
  input  logic              CoreRdEn,
  input  logic [ADDR_W-1:0] CoreAddr,
  input  logic [3:0]        CoreByteEn,
  input  logic [31:0]       CoreWrData,
  output logic              CoreStall,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [ADDR_W-1:0] CmdBaseAddr,
  input  logic [ADDR_W-1:0] CmdLen,
  input  logic [31:0]       CmdPattern,
  input  logic              CmdAbort,
  output logic              Busy,
  output logic              Done,
  output logic              Aborted,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic              MemRdEn,
  output logic [3:0]        MemByteEn,
  output logic [31:0]       MemWrData
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [31:0]         pat_q, pat_d;
  logic                abt_q, abt_d;
  logic                core_req;
  logic                force_slot;
  logic                eng_wr;

  assign core_req = CoreWrEn | CoreRdEn;

`ifdef VGA_FILL_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] blk_q, blk_d;

  assign force_slot = (state_q == S_FILL) && (blk_q == CNT_W'(STARVE_MAX));

  always_comb begin
    blk_d = blk_q;
    if (state_q != S_FILL)  blk_d = '0;
    else if (eng_wr)        blk_d = '0;
    else if (core_req)      blk_d = blk_q + 1'b1;
  end

  always_ff @(posedge QClk or negedge ResetN) begin
    if (!ResetN) blk_q <= '0;
    else         blk_q <= blk_d;
  end

  assign CoreStall = eng_wr & core_req;
`else
  logic unused_starve;
  assign unused_starve = (STARVE_MAX != 0);
  assign force_slot    = 1'b0;
  assign CoreStall     = 1'b0;
`endif

  // The abort cycle never writes, even if the guard would have forced a slot.
  assign eng_wr = (state_q == S_FILL) && !CmdAbort && (!core_req || force_slot);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    pat_d   = pat_q;
    abt_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          cur_d   = CmdBaseAddr;
          rem_d   = CmdLen;
          pat_d   = CmdPattern;
          state_d = (CmdLen == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (CmdAbort) begin
          state_d = S_DONE;
          abt_d   = 1'b1;
        end else if (eng_wr) begin
          cur_d = (cur_q == ADDR_W'(FB_DEPTH - 1)) ? '0 : cur_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == ADDR_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge QClk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      abt_q   <= abt_d;
    end
  end

  assign CmdReady = (state_q == S_IDLE);
  assign Busy     = (state_q == S_FILL);
  assign Done     = (state_q == S_DONE);
  assign Aborted  = abt_q;

  // Enables are gated by reset so the port is quiet while ResetN is low.
  always_comb begin
    if (eng_wr) begin
      MemAddr   = cur_q;
      MemWrEn   = ResetN;
      MemRdEn   = 1'b0;
      MemByteEn = 4'hF;
      MemWrData = pat_q;
    end else begin
      MemAddr   = CoreAddr;
      MemWrEn   = CoreWrEn & ResetN;
      MemRdEn   = CoreRdEn & ResetN;
      MemByteEn = CoreByteEn;
      MemWrData = CoreWrData;
    end
  end

endmodule

// File: tb/tb_vga_fill_arb.sv
// Directed bench for vga_fill_arb: cycle-script table plus hand sequences for long fills, arbitration, abort, reset and starvation.
module tb_vga_fill_arb;

  localparam logic [31:0] P  = 32'hA5A5_0001;
  localparam logic [31:0] CD = 32'h1234_5678;

  logic        QClk = 1'b0;
  logic        ResetN;
  logic        CoreWrEn, CoreRdEn;
  logic [13:0] CoreAddr;
  logic [3:0]  CoreByteEn;
  logic [31:0] CoreWrData;
  logic        CoreStall;
  logic        CmdValid, CmdReady;
  logic [13:0] CmdBaseAddr, CmdLen;
  logic [31:0] CmdPattern;
  logic        CmdAbort, Busy, Done, Aborted;
  logic [13:0] MemAddr;
  logic        MemWrEn, MemRdEn;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWrData;

  int tests = 0;
  int fails = 0;

  vga_fill_arb #(.FB_DEPTH(9600), .ADDR_W(14), .STARVE_MAX(16)) dut (
    .QClk(QClk), .ResetN(ResetN),
    .CoreWrEn(CoreWrEn), .CoreRdEn(CoreRdEn), .CoreAddr(CoreAddr),
    .CoreByteEn(CoreByteEn), .CoreWrData(CoreWrData), .CoreStall(CoreStall),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdBaseAddr(CmdBaseAddr),
    .CmdLen(CmdLen), .CmdPattern(CmdPattern), .CmdAbort(CmdAbort),
    .Busy(Busy), .Done(Done), .Aborted(Aborted),
    .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemRdEn(MemRdEn),
    .MemByteEn(MemByteEn), .MemWrData(MemWrData)
  );

  always #5 QClk = ~QClk;

  typedef struct {
    logic        wr, rd;
    logic [13:0] addr;
    logic        cv;
    logic [13:0] base, len;
    logic        abort;
    logic        e_wr, e_rd;
    logic [13:0] e_addr;
    logic [31:0] e_data;
    logic        e_busy, e_done, e_abt, e_rdy;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    CoreWrEn = 0; CoreRdEn = 0; CoreAddr = '0; CoreByteEn = 4'h3; CoreWrData = CD;
    CmdValid = 0; CmdBaseAddr = '0; CmdLen = '0; CmdPattern = P; CmdAbort = 0;
  endtask

  task automatic issue(input logic [13:0] base, input logic [13:0] len, input logic [31:0] pat);
    @(negedge QClk);
    CmdValid = 1; CmdBaseAddr = base; CmdLen = len; CmdPattern = pat;
    #1;
    chk("accept_ready", {63'd0, CmdReady}, 64'd1);
  endtask

  initial begin
    int nwr, bad, done_k, lastwr_k, ab;
    logic seen_done;

    //            wr rd addr  cv base  len abt  ewr erd eaddr edata busy done abt rdy
    tbl[0]  = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 0, 0, 14'd0,    CD, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 14'd5,   0, 14'd0,    14'd0,   0, 0, 1, 14'd5,    CD, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 14'd0,   1, 14'd9598, 14'd4,   0, 0, 0, 14'd0,    CD, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 1, 0, 14'd9598, P,  1, 0, 0, 0};
    tbl[4]  = '{1, 0, 14'd100, 0, 14'd0,    14'd0,   0, 1, 0, 14'd100,  CD, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 1, 0, 14'd9599, P,  1, 0, 0, 0};
    tbl[6]  = '{0, 1, 14'd7,   0, 14'd0,    14'd0,   0, 0, 1, 14'd7,    CD, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 1, 0, 14'd0,    P,  1, 0, 0, 0};
    tbl[8]  = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 1, 0, 14'd1,    P,  1, 0, 0, 0};
    tbl[9]  = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 0, 0, 14'd0,    CD, 0, 1, 0, 0};
    tbl[10] = '{0, 0, 14'd0,   1, 14'd50,   14'd0,   0, 0, 0, 14'd0,    CD, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 0, 0, 14'd0,    CD, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 14'd0,   1, 14'd200,  14'd100, 0, 0, 0, 14'd0,    CD, 0, 0, 0, 1};
    tbl[13] = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 1, 0, 14'd200,  P,  1, 0, 0, 0};
    tbl[14] = '{0, 0, 14'd0,   1, 14'd0,    14'd5,   0, 1, 0, 14'd201,  P,  1, 0, 0, 0};
    tbl[15] = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   1, 0, 0, 14'd0,    CD, 1, 0, 0, 0};
    tbl[16] = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   0, 0, 0, 14'd0,    CD, 0, 1, 1, 0};
    tbl[17] = '{0, 0, 14'd0,   0, 14'd0,    14'd0,   1, 0, 0, 14'd0,    CD, 0, 0, 0, 1};

    idle_inputs();
    ResetN = 0;
    #12;
    chk("reset_state", {56'd0, CmdReady, Busy, Done, Aborted, CoreStall, MemWrEn, MemRdEn, 1'b0},
        {56'd0, 8'b1000_0000});
    @(negedge QClk); ResetN = 1;

    // Cycle script through IDLE/FILL/DONE with wrap, core interleave, len=0 and abort.
    for (int unsigned i = 0; i < 18; i++) begin
      @(negedge QClk);
      CoreWrEn = tbl[i].wr; CoreRdEn = tbl[i].rd; CoreAddr = tbl[i].addr;
      CmdValid = tbl[i].cv; CmdBaseAddr = tbl[i].base; CmdLen = tbl[i].len; CmdAbort = tbl[i].abort;
      #1;
      chk($sformatf("table_row%0d", i),
          {12'd0, MemWrEn, MemRdEn, MemAddr, MemWrData, Busy, Done, Aborted, CmdReady},
          {12'd0, tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_data,
           tbl[i].e_busy, tbl[i].e_done, tbl[i].e_abt, tbl[i].e_rdy});
    end
    idle_inputs();

    // Full-screen clear.
    issue(14'd0, 14'd9600, 32'hFFFF_FFFF);
    nwr = 0; bad = 0; seen_done = 0; done_k = -1; lastwr_k = -1; ab = 0;
    for (int k = 0; k < 9700 && !seen_done; k++) begin
      @(negedge QClk); CmdValid = 0; #1;
      if (MemWrEn) begin
        if (MemAddr != 14'(nwr) || MemWrData != 32'hFFFF_FFFF || MemByteEn != 4'hF) bad++;
        nwr++; lastwr_k = k;
      end
      if (Done) begin seen_done = 1; done_k = k; ab = int'(Aborted); end
    end
    chk("clear_writes", 64'(nwr), 64'd9600);
    chk("clear_addr_data", 64'(bad), 64'd0);
    chk("clear_done_seen", {63'd0, seen_done}, 64'd1);
    chk("clear_done_timing", 64'(done_k - lastwr_k), 64'd1);
    chk("clear_aborted", 64'(ab), 64'd0);

    // Core store every other cycle; engine takes only the gaps.
    issue(14'd300, 14'd8, P);
    nwr = 0; bad = 0; seen_done = 0; done_k = -1; lastwr_k = -1;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      @(negedge QClk);
      CmdValid = 0; CoreWrEn = (k % 2 == 0); CoreAddr = 14'd100;
      #1;
      if (CoreWrEn) begin
        if (!MemWrEn || MemAddr != 14'd100 || MemWrData != CD || MemByteEn != 4'h3) bad++;
      end else if (MemWrEn) begin
        if (MemAddr != 14'(300 + nwr) || MemWrData != P || MemByteEn != 4'hF) bad++;
        nwr++; lastwr_k = k;
      end
      if (Done) begin seen_done = 1; done_k = k; end
    end
    idle_inputs();
    chk("arb_engine_writes", 64'(nwr), 64'd8);
    chk("arb_port_contents", 64'(bad), 64'd0);
    chk("arb_done_after_last", {63'd0, seen_done && (done_k == lastwr_k + 1)}, 64'd1);

    // Abort after ten writes.
    issue(14'd1000, 14'd100, P);
    nwr = 0;
    for (int k = 0; k < 30 && nwr < 10; k++) begin
      @(negedge QClk); CmdValid = 0; #1;
      if (MemWrEn) nwr++;
    end
    @(negedge QClk); CmdAbort = 1; #1;
    chk("abort_cycle_no_write", {62'd0, MemWrEn, Busy}, 64'b01);
    @(negedge QClk); CmdAbort = 0; #1;
    chk("abort_done_aborted", {62'd0, Done, Aborted}, 64'b11);
    chk("abort_write_count", 64'(nwr), 64'd10);

    // Asynchronous reset in the middle of a fill.
    issue(14'd0, 14'd50, P);
    for (int k = 0; k < 3; k++) begin @(negedge QClk); CmdValid = 0; end
    #2 ResetN = 0;
    #1;
    chk("rst_mid_fill", {60'd0, Busy, CmdReady, MemWrEn, Done}, 64'b0100);
    @(negedge QClk); ResetN = 1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge QClk); #1;
      if (Done || MemWrEn || Busy || !CmdReady) bad++;
    end
    chk("rst_after_release", 64'(bad), 64'd0);

    // Core requesting every cycle during a two-word fill.
    @(negedge QClk); CoreRdEn = 1; CoreAddr = 14'd9;
    issue(14'd500, 14'd2, P);
`ifdef VGA_FILL_STARVE_GUARD_EN
    begin
      int w0, w1, badstall;
      w0 = -1; w1 = -1; badstall = 0; seen_done = 0; done_k = -1;
      for (int k = 1; k <= 40 && !seen_done; k++) begin
        @(negedge QClk); CmdValid = 0; #1;
        if (MemWrEn) begin
          if (w0 < 0) w0 = k; else w1 = k;
          if (!CoreStall || MemRdEn) badstall++;
        end else if (CoreStall) badstall++;
        if (Done) begin seen_done = 1; done_k = k; end
      end
      chk("guard_first_write_cycle", 64'(w0), 64'd17);
      chk("guard_second_write_cycle", 64'(w1), 64'd34);
      chk("guard_stall_signalling", 64'(badstall), 64'd0);
      chk("guard_done_cycle", 64'(done_k), 64'd35);
    end
`else
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge QClk); CmdValid = 0; #1;
      if (MemWrEn || Done || CoreStall || !Busy || !MemRdEn) bad++;
    end
    chk("noguard_starved", 64'(bad), 64'd0);
    @(negedge QClk); CoreRdEn = 0;
    nwr = 0; seen_done = 0;
    for (int k = 0; k < 6 && !seen_done; k++) begin
      #1;
      if (MemWrEn) nwr++;
      if (Done) seen_done = 1;
      @(negedge QClk);
    end
    chk("noguard_release_writes", 64'(nwr), 64'd2);
    chk("noguard_release_done", {63'd0, seen_done}, 64'd1);
`endif
    idle_inputs();
    repeat (3) @(negedge QClk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
